// File: rtl/mic_sample_capture.sv
// mic_sample_capture: SPI master front end for the PmodMIC3 (ADCS7476).
// Runs one 16-SCLK conversion frame per SAMPLE_DIV board cycles and publishes
// the 12-bit raw word plus a 10-bit display/audio sample.
// Optional feature macro: MIC_AVG_EN (wave_sample becomes a 4-sample mean).
module mic_sample_capture #(
  parameter int unsigned SAMPLE_DIV = 5000,
  parameter int unsigned SCLK_HALF  = 25
) (
  input  logic        clk_100,
  input  logic        rst_n,
  input  logic        mic_miso,
  output logic        mic_cs_n,
  output logic        mic_sclk,
  output logic [11:0] mic_in,
  output logic [9:0]  wave_sample,
  output logic        sample_valid,
  output logic        overrun
);

  localparam int unsigned PCNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned HCNT_W  = (SCLK_HALF > 0) ? $clog2(2 * SCLK_HALF) : 1;
  localparam int unsigned BCNT_W  = 4;
  localparam int unsigned SHIFT_W = 16;
  localparam int unsigned RAW_W   = 12;
  localparam int unsigned WAVE_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [PCNT_W-1:0]    pcnt_q, pcnt_d;
  logic [HCNT_W-1:0]    hcnt_q, hcnt_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sclk_q, sclk_d;
  logic [RAW_W-1:0]     mic_in_q, mic_in_d;
  logic [WAVE_W-1:0]    wave_q, wave_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic                 tick_c;
  logic                 half_end_c;
  logic                 period_end_c;
  logic                 publish_c;
  logic [WAVE_W-1:0]    new_wave_c;

  // The leading-zero bits age out of the register; only bit 15 is never read.
  logic                 unused_shift_msb;
  assign unused_shift_msb = shift_q[SHIFT_W-1];

  // Period tick and SCLK phase boundaries decoded from the counters.
  assign tick_c       = (pcnt_q == PCNT_W'(SAMPLE_DIV - 1));
  assign half_end_c   = (hcnt_q == HCNT_W'(SCLK_HALF - 1));
  assign period_end_c = (hcnt_q == HCNT_W'(2 * SCLK_HALF - 1));
  assign publish_c    = (state_q == ST_HOLD) && half_end_c;
  assign new_wave_c   = shift_q[RAW_W-1:RAW_W-WAVE_W];

  // FSM state register.
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and frame-counter logic; SHIFT shifts MISO in as SCLK rises.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tick_c) begin
          state_d = ST_SETUP;
          hcnt_d  = '0;
        end
      end
      ST_SETUP: begin
        if (half_end_c) begin
          state_d = ST_SHIFT;
          hcnt_d  = '0;
          bcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (half_end_c) begin
          shift_d = {shift_q[SHIFT_W-2:0], mic_miso};
          if (bcnt_q == BCNT_W'(SHIFT_W - 1)) begin
            // High half of the last SCLK period is spent in HOLD.
            state_d = ST_HOLD;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end else if (period_end_c) begin
          hcnt_d = '0;
          bcnt_d = bcnt_q + 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (half_end_c) begin
          state_d = ST_IDLE;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: pin levels follow the next state so the pins are pure flops.
  always_comb begin
    cs_n_d    = (state_d == ST_IDLE);
    sclk_d    = !((state_d == ST_SHIFT) && (hcnt_d < HCNT_W'(SCLK_HALF)));
    pcnt_d    = tick_c ? '0 : pcnt_q + 1'b1;
    overrun_d = overrun_q | (tick_c && (state_q != ST_IDLE));
    mic_in_d  = mic_in_q;
    valid_d   = 1'b0;
    if (publish_c) begin
      mic_in_d = shift_q[RAW_W-1:0];
      valid_d  = 1'b1;
    end
  end

`ifdef MIC_AVG_EN
  logic [WAVE_W-1:0] hist0_q, hist0_d;
  logic [WAVE_W-1:0] hist1_q, hist1_d;
  logic [WAVE_W-1:0] hist2_q, hist2_d;
  logic [RAW_W-1:0]  avg_sum_c;

  // Running mean over the new sample and the three previous ones.
  always_comb begin
    hist0_d   = hist0_q;
    hist1_d   = hist1_q;
    hist2_d   = hist2_q;
    wave_d    = wave_q;
    avg_sum_c = RAW_W'(new_wave_c) + RAW_W'(hist0_q) + RAW_W'(hist1_q) + RAW_W'(hist2_q);
    if (publish_c) begin
      hist0_d = new_wave_c;
      hist1_d = hist0_q;
      hist2_d = hist1_q;
      wave_d  = avg_sum_c[RAW_W-1:RAW_W-WAVE_W];
    end
  end

  // Sample history registers.
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      hist0_q <= '0;
      hist1_q <= '0;
      hist2_q <= '0;
    end else begin
      hist0_q <= hist0_d;
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
    end
  end
`else
  // Display sample is the raw word with the two LSBs dropped.
  always_comb begin
    wave_d = wave_q;
    if (publish_c) begin
      wave_d = new_wave_c;
    end
  end
`endif

  // Datapath and output registers.
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      mic_in_q  <= '0;
      wave_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mic_in_q  <= mic_in_d;
      wave_q    <= wave_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign mic_cs_n     = cs_n_q;
  assign mic_sclk     = sclk_q;
  assign mic_in       = mic_in_q;
  assign wave_sample  = wave_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule
